// File: rtl/jtag_tap_core.sv
// Purpose : IEEE 1149.1-style TAP controller with IR, BYPASS, IDCODE and boundary-scan DRs.
// Latency : TDO is combinational from the selected shift register's bit 0; all state moves on TCK rise.
// Backpr. : none; TCK/TMS pacing from the board controller is the only flow control.
//
// Ports:
//   TCK, TRST        test clock and synchronous active-high reset
//   TMS, TDI         mode select and serial data in (sampled on TCK rise)
//   TDO, TDO_EN      serial data out, enabled only in Shift-IR / Shift-DR
//   state            current TAP state (4-bit IEEE encoding)
//   ir_out           active instruction
//   bsr_in, bsr_out  pin values to capture / update latch driving pins in EXTEST
//   extest_mode      high while EXTEST is the active instruction
module jtag_tap_core #(
  parameter int unsigned IR_WIDTH = 4,
  parameter int unsigned BSR_LEN  = 8,
  parameter logic [31:0] IDCODE   = 32'h1234_5673
) (
  input  logic                TCK,
  input  logic                TRST,
  input  logic                TMS,
  input  logic                TDI,
  output logic                TDO,
  output logic                TDO_EN,
  output logic [3:0]          state,
  output logic [IR_WIDTH-1:0] ir_out,
  input  logic [BSR_LEN-1:0]  bsr_in,
  output logic [BSR_LEN-1:0]  bsr_out,
  output logic                extest_mode
);

  typedef enum logic [3:0] {
    EX2DR = 4'h0, EX1DR = 4'h1, SHDR  = 4'h2, PADR  = 4'h3,
    SELIR = 4'h4, UPDR  = 4'h5, CAPDR = 4'h6, SELDR = 4'h7,
    EX2IR = 4'h8, EX1IR = 4'h9, SHIR  = 4'hA, PAIR  = 4'hB,
    RTI   = 4'hC, UPIR  = 4'hD, CAPIR = 4'hE, TLR   = 4'hF
  } tap_state_t;

  localparam logic [IR_WIDTH-1:0] INSTR_EXTEST = '0;
  localparam logic [IR_WIDTH-1:0] INSTR_IDCODE = IR_WIDTH'(1);
  localparam logic [IR_WIDTH-1:0] INSTR_SAMPLE = IR_WIDTH'(2);
  // Fixed 2'b01 pattern in the two LSBs lets the host check IR chain integrity.
  localparam logic [IR_WIDTH-1:0] IR_CAPTURE   = IR_WIDTH'(1);

  tap_state_t                st_q;
  tap_state_t                st_nxt;
  logic [IR_WIDTH-1:0]       ir_reg;
  logic [IR_WIDTH-1:0]       ir_shift;
  logic                      bypass_q;
  logic [31:0]               id_shift;
  logic [BSR_LEN-1:0]        bsr_shift;
  logic [IR_WIDTH-1:0]       ir_shift_nxt;
  logic [31:0]               id_shift_nxt;
  logic [BSR_LEN-1:0]        bsr_shift_nxt;
  logic                      sel_id;
  logic                      sel_bsr;

  // ---------------- FSM: state register ----------------
  always_ff @(posedge TCK) begin
    if (TRST) st_q <= TLR;
    else      st_q <= st_nxt;
  end

  // ---------------- FSM: next state ----------------
  always_comb begin
    st_nxt = st_q;
    unique case (st_q)
      TLR:   st_nxt = TMS ? TLR   : RTI;
      RTI:   st_nxt = TMS ? SELDR : RTI;
      SELDR: st_nxt = TMS ? SELIR : CAPDR;
      SELIR: st_nxt = TMS ? TLR   : CAPIR;
      CAPDR: st_nxt = TMS ? EX1DR : SHDR;
      SHDR:  st_nxt = TMS ? EX1DR : SHDR;
      EX1DR: st_nxt = TMS ? UPDR  : PADR;
      PADR:  st_nxt = TMS ? EX2DR : PADR;
      EX2DR: st_nxt = TMS ? UPDR  : SHDR;
      UPDR:  st_nxt = TMS ? SELDR : RTI;
      CAPIR: st_nxt = TMS ? EX1IR : SHIR;
      SHIR:  st_nxt = TMS ? EX1IR : SHIR;
      EX1IR: st_nxt = TMS ? UPIR  : PAIR;
      PAIR:  st_nxt = TMS ? EX2IR : PAIR;
      EX2IR: st_nxt = TMS ? UPIR  : SHIR;
      UPIR:  st_nxt = TMS ? SELDR : RTI;
      default: st_nxt = TLR;
    endcase
  end

  // ---------------- FSM: outputs ----------------
  always_comb begin
    TDO_EN = 1'b0;
    TDO    = 1'b0;
    if (st_q == SHIR) begin
      TDO_EN = 1'b1;
      TDO    = ir_shift[0];
    end else if (st_q == SHDR) begin
      TDO_EN = 1'b1;
      if (sel_id)       TDO = id_shift[0];
      else if (sel_bsr) TDO = bsr_shift[0];
      else              TDO = bypass_q;
    end
  end

  assign state = st_q;

  // TLR presents IDCODE immediately on entry, not one TCK later.
  assign ir_out      = (st_q == TLR) ? INSTR_IDCODE : ir_reg;
  assign extest_mode = (ir_out == INSTR_EXTEST);
  assign sel_id      = (ir_out == INSTR_IDCODE);
  assign sel_bsr     = (ir_out == INSTR_EXTEST) || (ir_out == INSTR_SAMPLE);

  // Right shifts with TDI entering the MSB; written without part-selects so a
  // 1-bit BSR still elaborates.
  always_comb begin
    ir_shift_nxt                 = ir_shift >> 1;
    ir_shift_nxt[IR_WIDTH-1]     = TDI;
    id_shift_nxt                 = id_shift >> 1;
    id_shift_nxt[31]             = TDI;
    bsr_shift_nxt                = bsr_shift >> 1;
    bsr_shift_nxt[BSR_LEN-1]     = TDI;
  end

  // ---------------- Scan registers ----------------
  always_ff @(posedge TCK) begin
    if (TRST) begin
      ir_reg    <= INSTR_IDCODE;
      ir_shift  <= '0;
      bypass_q  <= 1'b0;
      id_shift  <= '0;
      bsr_shift <= '0;
      bsr_out   <= '0;
    end else begin
      unique case (st_q)
        TLR:   ir_reg   <= INSTR_IDCODE;
        CAPIR: ir_shift <= IR_CAPTURE;
        SHIR:  ir_shift <= ir_shift_nxt;
        UPIR:  ir_reg   <= ir_shift;
        CAPDR: begin
          if (sel_id)       id_shift  <= IDCODE;
          else if (sel_bsr) bsr_shift <= bsr_in;
          else              bypass_q  <= 1'b0;
        end
        SHDR: begin
          if (sel_id)       id_shift  <= id_shift_nxt;
          else if (sel_bsr) bsr_shift <= bsr_shift_nxt;
          else              bypass_q  <= TDI;
        end
        UPDR: begin
          if (sel_bsr) bsr_out <= bsr_shift;
        end
        default: ;  // select, pause and exit states hold everything
      endcase
    end
  end

endmodule

// File: tb/tb_jtag_tap_core.sv
module tb_jtag_tap_core;

  localparam int IRW = 4;
  localparam int BSL = 8;
  localparam logic [31:0] IDC = 32'h1234_5673;

  // IEEE state codes
  localparam logic [3:0] S_EX2DR = 4'h0, S_EX1DR = 4'h1, S_SHDR = 4'h2, S_PADR = 4'h3,
                         S_SELIR = 4'h4, S_UPDR = 4'h5, S_CAPDR = 4'h6, S_SELDR = 4'h7,
                         S_EX2IR = 4'h8, S_EX1IR = 4'h9, S_SHIR = 4'hA, S_PAIR = 4'hB,
                         S_RTI = 4'hC, S_UPIR = 4'hD, S_CAPIR = 4'hE, S_TLR = 4'hF;

  logic           TCK, TRST, TMS, TDI;
  logic           TDO, TDO_EN;
  logic [3:0]     state;
  logic [IRW-1:0] ir_out;
  logic [BSL-1:0] bsr_in, bsr_out;
  logic           extest_mode;

  int checks = 0;
  int errors = 0;
  bit chk_en = 0;

  jtag_tap_core #(.IR_WIDTH(IRW), .BSR_LEN(BSL), .IDCODE(IDC)) dut (
    .TCK(TCK), .TRST(TRST), .TMS(TMS), .TDI(TDI),
    .TDO(TDO), .TDO_EN(TDO_EN), .state(state), .ir_out(ir_out),
    .bsr_in(bsr_in), .bsr_out(bsr_out), .extest_mode(extest_mode)
  );

  initial begin
    TCK = 1'b0;
    forever #5 TCK = ~TCK;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- Reference model ----------------
  // TAP walk table straight from the IEEE transition list.
  function automatic logic [3:0] tap_next(input logic [3:0] s, input logic tms);
    logic [3:0] on0, on1;
    case (s)
      S_TLR:   begin on0 = S_RTI;   on1 = S_TLR;   end
      S_RTI:   begin on0 = S_RTI;   on1 = S_SELDR; end
      S_SELDR: begin on0 = S_CAPDR; on1 = S_SELIR; end
      S_SELIR: begin on0 = S_CAPIR; on1 = S_TLR;   end
      S_CAPDR, S_SHDR, S_EX2DR: begin on0 = S_SHDR; on1 = (s == S_EX2DR) ? S_UPDR : S_EX1DR; end
      S_EX1DR: begin on0 = S_PADR;  on1 = S_UPDR;  end
      S_PADR:  begin on0 = S_PADR;  on1 = S_EX2DR; end
      S_CAPIR, S_SHIR, S_EX2IR: begin on0 = S_SHIR; on1 = (s == S_EX2IR) ? S_UPIR : S_EX1IR; end
      S_EX1IR: begin on0 = S_PAIR;  on1 = S_UPIR;  end
      S_PAIR:  begin on0 = S_PAIR;  on1 = S_EX2IR; end
      default: begin on0 = S_RTI;   on1 = S_SELDR; end // UPDR / UPIR
    endcase
    return tms ? on1 : on0;
  endfunction

  logic [3:0]     m_state;
  logic [IRW-1:0] m_ir, m_irsh;
  logic           m_byp;
  logic [31:0]    m_id;
  logic [BSL-1:0] m_bsh, m_bout;
  int             m_sel;   // 0 bypass, 1 idcode, 2 boundary scan

  function automatic logic [IRW-1:0] m_ir_vis();
    return (m_state == S_TLR) ? IRW'(1) : m_ir;
  endfunction

  function automatic int dr_of(input logic [IRW-1:0] ir);
    if (ir == 1) return 1;
    if (ir == 0 || ir == 2) return 2;
    return 0;
  endfunction

  always @(posedge TCK) begin
    if (TRST) begin
      m_state = S_TLR; m_ir = 1; m_irsh = 0; m_byp = 0; m_id = 0; m_bsh = 0; m_bout = 0;
    end else begin
      m_sel = dr_of(m_ir_vis());
      if (m_state == S_TLR)   m_ir = 1;
      if (m_state == S_CAPIR) m_irsh = 1;
      if (m_state == S_SHIR)  m_irsh = (m_irsh >> 1) + (IRW'(TDI) << (IRW - 1));
      if (m_state == S_UPIR)  m_ir = m_irsh;
      if (m_state == S_CAPDR) begin
        if (m_sel == 1) m_id = IDC;
        else if (m_sel == 2) m_bsh = bsr_in;
        else m_byp = 0;
      end
      if (m_state == S_SHDR) begin
        if (m_sel == 1) m_id = (m_id >> 1) + (32'(TDI) << 31);
        else if (m_sel == 2) m_bsh = (m_bsh >> 1) + (BSL'(TDI) << (BSL - 1));
        else m_byp = TDI;
      end
      if (m_state == S_UPDR && m_sel == 2) m_bout = m_bsh;
      m_state = tap_next(m_state, TMS);
    end
  end

  // Compare process: every falling edge once the model is defined.
  always @(negedge TCK) begin
    if (chk_en) begin
      logic exp_en, exp_tdo;
      int   sel;
      exp_en  = (m_state == S_SHIR) || (m_state == S_SHDR);
      sel     = dr_of(m_ir_vis());
      exp_tdo = 1'b0;
      if (m_state == S_SHIR) exp_tdo = m_irsh[0];
      if (m_state == S_SHDR) exp_tdo = (sel == 1) ? m_id[0] : (sel == 2) ? m_bsh[0] : m_byp;
      check("state",       32'(state),       32'(m_state));
      check("ir_out",      32'(ir_out),      32'(m_ir_vis()));
      check("bsr_out",     32'(bsr_out),     32'(m_bout));
      check("extest_mode", 32'(extest_mode), 32'(m_ir_vis() == 0));
      check("TDO_EN",      32'(TDO_EN),      32'(exp_en));
      check("TDO",         32'(TDO),         32'(exp_tdo));
    end
  end

  // ---------------- Stimulus helpers ----------------
  // Called at a falling edge; returns TDO as seen before the rising edge.
  task automatic step(input logic tms, input logic tdi, output logic tdo_seen);
    TMS = tms; TDI = tdi;
    tdo_seen = TDO;
    @(posedge TCK);
    @(negedge TCK);
  endtask

  task automatic walk(input logic tms);
    logic d;
    step(tms, 1'b0, d);
  endtask

  // RTI -> load IR -> RTI
  task automatic load_ir(input logic [IRW-1:0] v);
    logic d;
    walk(1); walk(1); walk(0); walk(0);         // SELDR SELIR CAPIR SHIR
    for (int i = 0; i < IRW; i++) step(i == IRW - 1, v[i], d);
    walk(1); walk(0);                           // UPIR RTI
  endtask

  initial begin
    logic        d;
    logic [31:0] got;
    logic [3:0]  pat;
    logic [3:0]  exp4;
    logic [5:0]  seq;

    TRST = 1; TMS = 0; TDI = 0; bsr_in = '0;
    @(negedge TCK);

    // T1 reset
    step(1'($urandom), 1'b0, d);
    chk_en = 1;
    step(1'($urandom), 1'b0, d);
    check("t1_state",  32'(state),   32'hF);
    check("t1_ir",     32'(ir_out),  32'h1);
    check("t1_bsr",    32'(bsr_out), 32'h0);
    check("t1_tdo_en", 32'(TDO_EN),  32'h0);
    TRST = 0;

    // T2 IDCODE read
    walk(0); walk(1); walk(0); walk(0);          // RTI SELDR CAPDR SHDR
    check("t2_in_shdr", 32'(state), 32'h2);
    got = '0;
    for (int i = 0; i < 32; i++) begin
      step(i == 31, 1'($urandom), d);
      got[i] = d;
    end
    check("t2_idcode", got, 32'h1234_5673);
    walk(1); walk(0);                           // UPDR RTI

    // T3 BYPASS
    load_ir(4'hF);
    check("t3_ir", 32'(ir_out), 32'hF);
    walk(1); walk(0); walk(0);                  // SELDR CAPDR SHDR
    pat  = 4'b1101;                             // TDI order 1,0,1,1 (bit0 first)
    exp4 = 4'b1010;                             // TDO order 0,1,0,1
    for (int i = 0; i < 4; i++) begin
      step(i == 3, pat[i], d);
      check("t3_bypass_tdo", 32'(d), 32'(exp4[i]));
    end
    walk(1); walk(0);

    // T4 EXTEST
    load_ir(4'h0);
    check("t4_ir", 32'(ir_out), 32'h0);
    bsr_in = 8'hA5;
    walk(1); walk(0); walk(0);
    got = '0;
    for (int i = 0; i < 8; i++) begin
      logic [7:0] v;
      v = 8'h3C;
      step(i == 7, v[i], d);
      got[i] = d;
    end
    check("t4_capture", got, 32'hA5);
    walk(1); walk(0);                           // UPDR RTI
    check("t4_bsr_out", 32'(bsr_out),     32'h3C);
    check("t4_extest",  32'(extest_mode), 32'h1);

    // T5 soft reset mid-shift (bypass selected so the UPDR pass leaves pins alone)
    load_ir(4'hF);
    walk(1); walk(0); walk(0);
    for (int i = 0; i < 3; i++) step(1'b0, 1'($urandom), d);
    for (int i = 0; i < 5; i++) walk(1);
    check("t5_state", 32'(state),   32'hF);
    check("t5_ir",    32'(ir_out),  32'h1);
    check("t5_bsr",   32'(bsr_out), 32'h3C);

    // T6 IR pause: capture 01, pause, resume; data must be continuous
    walk(0); walk(1); walk(1); walk(0); walk(0); // RTI SELDR SELIR CAPIR SHIR
    step(1'b0, 1'b1, d); seq[0] = d;
    step(1'b1, 1'b0, d); seq[1] = d;            // -> EX1IR
    walk(0); walk(0); walk(0);                  // PAIR x3
    check("t6_pause", 32'(state), 32'hB);
    walk(1); walk(0);                           // EX2IR SHIR
    for (int i = 0; i < 4; i++) begin
      step(i == 3, 1'b0, d);
      seq[2 + i] = d;
    end
    check("t6_tdo_seq", 32'(seq), 32'(6'b010001)); // 1,0,0,0,1,0 bit0 first
    walk(1); walk(0);                           // UPIR RTI
    check("t6_ir", 32'(ir_out), 32'h0);

    // Random phase, model-checked every cycle
    for (int n = 0; n < 4000; n++) begin
      TRST   = ($urandom_range(0, 199) == 0);
      bsr_in = 8'($urandom);
      step($urandom_range(0, 99) < 30, 1'($urandom), d);
    end
    TRST = 0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
